// File: rtl/lsu_mmio.sv
// Load-store unit: byte/half/word access to an internal synchronous DMEM and a memory-mapped I/O page.
// Optional macro LSU_SW_SYNC_EN adds a 2-flop synchroniser on the switch inputs.
module lsu_mmio #(
    parameter int          DMEM_BYTES = 2048,
    parameter logic [31:0] DMEM_BASE  = 32'h0000_2000,
    parameter logic [31:0] IO_BASE    = 32'h0000_7000,
    parameter int          NUM_HEX    = 8,
    parameter int          LEDR_W     = 17,
    parameter int          LEDG_W     = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [2:0]             req_funct3_i,
    input  logic [31:0]            req_addr_i,
    input  logic [31:0]            req_wdata_i,
    output logic                   rsp_valid_o,
    output logic [31:0]            rsp_rdata_o,
    output logic                   rsp_err_o,
    input  logic [31:0]            io_sw_i,
    output logic [LEDR_W-1:0]      io_ledr_o,
    output logic [LEDG_W-1:0]      io_ledg_o,
    output logic [31:0]            io_lcd_o,
    output logic [8*NUM_HEX-1:0]   io_hex_o
);

    localparam int DMEM_WORDS = DMEM_BYTES / 4;
    localparam int AW         = $clog2(DMEM_WORDS);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t state, state_next;
    logic   accept;

    logic [31:0] sw_val;
    logic        funct3_ok;
    logic        misaligned;
    logic [3:0]  be;
    logic [31:0] wmask;
    logic [31:0] wdata_sh;

    logic [9:0]         io_word;
    logic               io_page;
    logic               dmem_hit;
    logic               sel_ledr;
    logic               sel_ledg;
    logic               sel_lcd;
    logic               sel_sw;
    logic [NUM_HEX-1:0] sel_hex;
    logic               io_hit;
    logic               err;
    logic               wr_ok;
    logic [31:0]        io_rdata;
    logic [AW-1:0]      dmem_idx;

    logic [31:0] mem [DMEM_WORDS];
    logic [31:0] mem_q;
    logic [31:0] io_q;
    logic        resp_err;
    logic        resp_load;
    logic        resp_dmem;
    logic [2:0]  resp_funct3;
    logic [1:0]  resp_off;
    logic [31:0] raw;
    logic [31:0] shifted;
    logic [31:0] ext;

`ifdef LSU_SW_SYNC_EN
    logic [31:0] sw_meta;
    logic [31:0] sw_sync;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= io_sw_i;
            sw_sync <= sw_meta;
        end
    end

    assign sw_val = sw_sync;
`else
    assign sw_val = io_sw_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake and response strobes are gated by reset so a request caught in RESP never responds.
    always_comb begin
        state_next  = state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = rst_ni;
                if (req_valid_i && rst_ni) begin
                    accept     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = rst_ni;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Width decode: byte enables and store data are moved into their little-endian lanes.
    always_comb begin
        funct3_ok  = 1'b1;
        misaligned = 1'b0;
        be         = 4'b0000;
        wdata_sh   = req_wdata_i;
        case (req_funct3_i)
            3'b000, 3'b100: begin
                be       = 4'b0001 << req_addr_i[1:0];
                wdata_sh = req_wdata_i << {req_addr_i[1:0], 3'b000};
            end
            3'b001, 3'b101: begin
                be         = 4'b0011 << {req_addr_i[1], 1'b0};
                wdata_sh   = req_wdata_i << {req_addr_i[1], 4'b0000};
                misaligned = req_addr_i[0];
            end
            3'b010: begin
                be         = 4'b1111;
                misaligned = |req_addr_i[1:0];
            end
            default: funct3_ok = 1'b0;
        endcase
        for (int b = 0; b < 4; b++) begin
            wmask[8*b +: 8] = {8{be[b]}};
        end
    end

    assign io_word  = req_addr_i[11:2];
    assign io_page  = req_addr_i[31:12] == IO_BASE[31:12];
    assign dmem_hit = req_addr_i[31:AW+2] == DMEM_BASE[31:AW+2];
    assign dmem_idx = req_addr_i[AW+1:2];
    assign sel_ledr = io_page && (io_word == 10'h000);
    assign sel_ledg = io_page && (io_word == 10'h004);
    assign sel_lcd  = io_page && (io_word == 10'h008);
    assign sel_sw   = io_page && (io_word == 10'h200);

    always_comb begin
        sel_hex = '0;
        for (int n = 0; n < NUM_HEX; n++) begin
            sel_hex[n] = io_page && (io_word == 10'(12 + n));
        end
    end

    assign io_hit = sel_ledr || sel_ledg || sel_lcd || sel_sw || (|sel_hex);
    assign err    = !funct3_ok || misaligned || !(dmem_hit || io_hit) || (req_we_i && sel_sw);
    assign wr_ok  = accept && req_we_i && !err;

    // Peripheral read word, zero-filled above each register's width.
    always_comb begin
        io_rdata = '0;
        if (sel_ledr) io_rdata[LEDR_W-1:0] = io_ledr_o;
        if (sel_ledg) io_rdata[LEDG_W-1:0] = io_ledg_o;
        if (sel_lcd)  io_rdata = io_lcd_o;
        if (sel_sw)   io_rdata = sw_val;
        for (int n = 0; n < NUM_HEX; n++) begin
            if (sel_hex[n]) io_rdata[7:0] = io_hex_o[8*n +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_q <= mem[dmem_idx];
        end
        if (wr_ok && dmem_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[dmem_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    // Peripheral registers merge only the enabled byte lanes; HEX registers hold only lane 0.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            io_ledr_o <= '0;
            io_ledg_o <= '0;
            io_lcd_o  <= '0;
            io_hex_o  <= '1;
        end else if (wr_ok && io_hit) begin
            if (sel_ledr) begin
                io_ledr_o <= (io_ledr_o & ~wmask[LEDR_W-1:0]) | (wdata_sh[LEDR_W-1:0] & wmask[LEDR_W-1:0]);
            end
            if (sel_ledg) begin
                io_ledg_o <= (io_ledg_o & ~wmask[LEDG_W-1:0]) | (wdata_sh[LEDG_W-1:0] & wmask[LEDG_W-1:0]);
            end
            if (sel_lcd) begin
                io_lcd_o <= (io_lcd_o & ~wmask) | (wdata_sh & wmask);
            end
            for (int n = 0; n < NUM_HEX; n++) begin
                if (sel_hex[n] && be[0]) io_hex_o[8*n +: 8] <= wdata_sh[7:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_err    <= 1'b0;
            resp_load   <= 1'b0;
            resp_dmem   <= 1'b0;
            resp_funct3 <= 3'b000;
            resp_off    <= 2'b00;
            io_q        <= '0;
        end else if (accept) begin
            resp_err    <= err;
            resp_load   <= !req_we_i;
            resp_dmem   <= dmem_hit;
            resp_funct3 <= req_funct3_i;
            resp_off    <= req_addr_i[1:0];
            io_q        <= io_rdata;
        end
    end

    // Lane extraction and sign/zero extension of the latched word.
    always_comb begin
        raw     = resp_dmem ? mem_q : io_q;
        shifted = raw >> {resp_off, 3'b000};
        case (resp_funct3)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign rsp_rdata_o = (rsp_valid_o && resp_load && !resp_err) ? ext : 32'h0;
    assign rsp_err_o   = rsp_valid_o && resp_err;

endmodule

// File: tb/tb_lsu_mmio.sv
// Scoreboard testbench for lsu_mmio: byte-level reference model, randomized and directed requests.
// Honours LSU_SW_SYNC_EN for the switch-latency check.
module tb_lsu_mmio;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] io_sw;
    logic [16:0] io_ledr;
    logic [7:0]  io_ledg;
    logic [31:0] io_lcd;
    logic [63:0] io_hex;

    lsu_mmio dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .io_sw_i      (io_sw),
        .io_ledr_o    (io_ledr),
        .io_ledg_o    (io_ledg),
        .io_lcd_o     (io_lcd),
        .io_hex_o     (io_hex)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [7:0]  dm [logic [31:0]];
    logic [31:0] preg [11];
    logic [31:0] pmask [11];
    logic [31:0] sw_model;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name, input int act, input int exp);
        tests++;
        fails++;
        $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic resetModel();
        for (int i = 0; i < 11; i++) preg[i] = (i >= 3) ? 32'hFF : 32'h0;
    endtask

    // Reference model: whole-request semantics from address map and width rules.
    task automatic modelAccess(input bit we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int size, reg_i, off, lane;
        logic is_dmem, is_sw;
        logic [31:0] word, val;
        reg_i = -1; is_dmem = 0; is_sw = 0; val = 0; rd = 0; word = 0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (a >= 32'h2000 && a < 32'h2800) is_dmem = 1;
        else if (a[31:12] == 20'h7) begin
            off = int'(a[11:0]) & ~3;
            if (off == 0) reg_i = 0;
            else if (off == 16) reg_i = 1;
            else if (off == 32) reg_i = 2;
            else if (off >= 48 && off < 80) reg_i = 3 + (off - 48) / 4;
            else if (off == 2048) is_sw = 1;
        end
        err = (size == 0);
        if (!err) err = (a & 32'(size - 1)) != 0;
        if (!is_dmem && reg_i < 0 && !is_sw) err = 1;
        if (we && is_sw) err = 1;
        if (err) return;
        if (is_sw) word = sw_model;
        else if (reg_i >= 0) word = preg[reg_i];
        for (int i = 0; i < size; i++) begin
            lane = int'(a[1:0]) + i;
            if (is_dmem) begin
                if (we) dm[32'(a + i)] = wd[8*i +: 8];
                else val[8*i +: 8] = dm[32'(a + i)];
            end else begin
                if (we) word[8*lane +: 8] = wd[8*i +: 8];
                else val[8*i +: 8] = word[8*lane +: 8];
            end
        end
        if (we && reg_i >= 0) preg[reg_i] = word & pmask[reg_i];
        if (!we) begin
            case (f3)
                3'd0:    rd = {{24{val[7]}}, val[7:0]};
                3'd1:    rd = {{16{val[15]}}, val[15:0]};
                default: rd = val;
            endcase
        end
    endtask

    task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input bit expect_rsp);
        logic [31:0] rd;
        logic e;
        bit accepted;
        accepted = 0;
        @(posedge clk);
        #1;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (req_ready) begin
                modelAccess(we, f3, a, wd, rd, e);
                if (expect_rsp) sb.push_back('{rd, e, cyc + 1});
                accepted = 1;
            end
        end
        if (!accepted) failNow("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic checkOutput();
        logic [63:0] hex_exp;
        @(negedge clk);
        for (int n = 0; n < 8; n++) hex_exp[8*n +: 8] = preg[3 + n][7:0];
        check("ledr", 64'(io_ledr), 64'(preg[0]));
        check("ledg", 64'(io_ledg), 64'(preg[1]));
        check("lcd", 64'(io_lcd), 64'(preg[2]));
        check("hex", io_hex, hex_exp);
    endtask

    // Monitor: pops the scoreboard whenever a response appears, checks data, error and latency.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                failNow("unexpected_rsp", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
                check("rsp_latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end else begin
            check("idle_zero", {31'h0, rsp_err, rsp_rdata}, 64'h0);
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                failNow("missing_rsp", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    function automatic logic [31:0] randAddr();
        logic [31:0] offs [5];
        logic [31:0] bad [6];
        offs = '{32'h000, 32'h010, 32'h020, 32'h030, 32'h800};
        bad  = '{32'h2800, 32'h1FFC, 32'h7004, 32'h7050, 32'h6000, 32'h7FFC};
        case ($urandom % 10)
            0, 1, 2, 3, 4: return 32'h2000 + ($urandom % 64);
            5:             return 32'h27FC + ($urandom % 4);
            6, 7: begin
                int k;
                k = $urandom % 5;
                if (k == 3) return 32'h7000 + offs[3] + 4 * ($urandom % 8) + ($urandom % 4);
                return 32'h7000 + offs[k] + ($urandom % 4);
            end
            default:       return bad[$urandom % 6] + ($urandom % 4);
        endcase
    endfunction

    function automatic logic [2:0] randF3();
        logic [2:0] legal [5];
        legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        if ($urandom % 10 == 0) return 3'd3 + 3'(($urandom % 3) * 3 % 5);
        return legal[$urandom % 5];
    endfunction

    initial begin
        rst_ni = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; io_sw = 32'h0; sw_model = 32'h0;
        for (int i = 0; i < 11; i++) pmask[i] = (i == 0) ? 32'h1FFFF : (i == 2) ? 32'hFFFF_FFFF : 32'hFF;
        resetModel();
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        @(negedge clk);
        check("reset_ready", 64'(req_ready), 64'h1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        checkOutput();

        for (int i = 0; i < 16; i++) applyStimulus(1, 3'd2, 32'h2000 + 4 * i, $urandom, 1);
        applyStimulus(1, 3'd2, 32'h27FC, $urandom, 1);

        applyStimulus(1, 3'd2, 32'h2000, 32'hDEADBEEF, 1);
        applyStimulus(0, 3'd0, 32'h2003, 0, 1);
        applyStimulus(0, 3'd4, 32'h2003, 0, 1);
        applyStimulus(0, 3'd1, 32'h2002, 0, 1);
        applyStimulus(0, 3'd5, 32'h2002, 0, 1);
        applyStimulus(0, 3'd2, 32'h2000, 0, 1);

        applyStimulus(1, 3'd0, 32'h7038, 32'h5A, 1);
        applyStimulus(1, 3'd2, 32'h7000, 32'h1FFFF, 1);
        applyStimulus(0, 3'd2, 32'h7000, 0, 1);
        checkOutput();
        check("hex2_direct", 64'(io_hex), 64'hFFFF_FFFF_FF5A_FFFF);
        check("ledr_direct", 64'(io_ledr), 64'h1FFFF);

        applyStimulus(0, 3'd2, 32'h2002, 0, 1);
        applyStimulus(1, 3'd1, 32'h2001, 32'h1234, 1);
        applyStimulus(0, 3'd2, 32'h6000, 0, 1);
        applyStimulus(1, 3'd2, 32'h7800, 32'hFFFF, 1);
        applyStimulus(0, 3'd3, 32'h2000, 0, 1);
        applyStimulus(0, 3'd2, 32'h2000, 0, 1);
        checkOutput();

        // Held request: accepted every other cycle.
        @(posedge clk);
        #1;
        req_we = 0; req_funct3 = 3'd2; req_addr = 32'h2000; req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] rd;
            logic e;
            @(negedge clk);
            check("hold_ready", 64'(req_ready), 64'((i % 2) == 0));
            if (req_ready) begin
                modelAccess(0, 3'd2, 32'h2000, 0, rd, e);
                sb.push_back('{rd, e, cyc + 1});
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;

        // Reset while a load sits in RESP.
        applyStimulus(1, 3'd2, 32'h7010, 32'hFF, 1);
        applyStimulus(1, 3'd2, 32'h7020, 32'hCAFE_F00D, 1);
        checkOutput();
        @(posedge clk);
        #1;
        req_we = 0; req_funct3 = 3'd2; req_addr = 32'h7010; req_valid = 1'b1;
        @(negedge clk);
        check("rst_pre_ready", 64'(req_ready), 64'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk);
        check("rst_no_rsp", 64'(rsp_valid), 64'h0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        resetModel();
        checkOutput();
        applyStimulus(0, 3'd2, 32'h2000, 0, 1);

        io_sw = 32'h12345678;
        repeat (3) @(posedge clk);
        sw_model = io_sw;
        applyStimulus(0, 3'd2, 32'h7800, 0, 1);
        applyStimulus(0, 3'd0, 32'h7801, 0, 1);
        applyStimulus(0, 3'd1, 32'h7802, 0, 1);

`ifdef LSU_SW_SYNC_EN
        @(posedge clk);
        #1 io_sw = 32'h8765_4321;
        applyStimulus(0, 3'd2, 32'h7800, 0, 1);
        repeat (3) @(posedge clk);
        sw_model = io_sw;
        applyStimulus(0, 3'd2, 32'h7800, 0, 1);
`endif

        for (int t = 0; t < 300; t++) begin
            if ($urandom % 20 == 0) begin
                io_sw = $urandom;
                repeat (3) @(posedge clk);
                sw_model = io_sw;
            end
            applyStimulus(1'($urandom % 2), randF3(), randAddr(), $urandom, 1);
            if ($urandom % 4 == 0) repeat ($urandom % 3) @(posedge clk);
            if (t % 50 == 49) checkOutput();
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
